// File: rtl/rcm_seq.sv
`default_nettype none
// ============================================================================
// Module   : rcm_seq
// Brief    : Reset sequencer: synchronised POR release, staggered per-domain
//            resets, SCL-inactivity watchdog and ring-oscillator enable.
// Revision : 1.0 - initial release
// ============================================================================
module rcm_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int N_CH        = 4,
    parameter int DLY_W       = 4,
    parameter int WD_W        = 16
) (
    input  logic              xtal_clk,
    input  logic              por_rst,
    input  logic              sw_rst_req,
    input  logic              hif_active,
    input  logic              hif_scl,
    input  logic              wd_en,
    input  logic [WD_W-1:0]   wd_limit,
    input  logic [DLY_W-1:0]  stagger,
    output logic [N_CH-1:0]   rst_n,
    output logic              rst_done,
    output logic              wd_timeout,
    output logic              slow_clk_en
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_CH - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [DLY_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [WD_W-1:0]        r_wd_cnt;
    logic                   r_scl_s1;
    logic                   r_scl_s2;
    logic                   r_scl_h;

    logic                   w_sync_ok;
    logic [1:0]             w_state_nxt;
    logic [DLY_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [N_CH-1:0]        w_rst_n_nxt;
    logic                   w_done_nxt;
    logic                   w_scl_edge;
    logic                   w_wd_run;

    assign w_sync_ok = r_sync[SYNC_STAGES-1];

    // A software request empties the chain so the synchroniser wait restarts.
    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            r_sync <= '0;
        end else if (sw_rst_req) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = rst_n;
        w_done_nxt  = rst_done;
        case (r_state)
            c_ST_ASSERT: begin
                w_rst_n_nxt = '0;
                w_done_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                if (!sw_rst_req && w_sync_ok) begin
                    w_state_nxt = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                if (sw_rst_req) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == stagger) begin
                    w_rst_n_nxt = rst_n | (N_CH'(1) << r_idx);
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = c_ST_RUN;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DLY_W'(1);
                end
            end
            c_ST_RUN: begin
                if (sw_rst_req) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_ASSERT;
                w_rst_n_nxt = '0;
                w_done_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            r_state  <= c_ST_ASSERT;
            r_cnt    <= '0;
            r_idx    <= '0;
            rst_n    <= '0;
            rst_done <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            rst_n    <= w_rst_n_nxt;
            rst_done <= w_done_nxt;
        end
    end

    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            r_scl_s1 <= 1'b0;
            r_scl_s2 <= 1'b0;
            r_scl_h  <= 1'b0;
        end else begin
            r_scl_s1 <= hif_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
        end
    end

    assign w_scl_edge = r_scl_s2 ^ r_scl_h;
    assign w_wd_run   = (r_state == c_ST_RUN) && wd_en && hif_active && (wd_limit != '0);

    // The >= compare keeps the counter from wrapping if wd_limit is lowered mid-count.
    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            r_wd_cnt   <= '0;
            wd_timeout <= 1'b0;
        end else if (!w_wd_run || w_scl_edge) begin
            r_wd_cnt   <= '0;
            wd_timeout <= 1'b0;
        end else if (r_wd_cnt >= wd_limit) begin
            r_wd_cnt   <= '0;
            wd_timeout <= 1'b1;
        end else begin
            r_wd_cnt   <= r_wd_cnt + WD_W'(1);
            wd_timeout <= 1'b0;
        end
    end

    // Keyed on the next state so the enable tracks the state it is reported with.
    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            slow_clk_en <= 1'b1;
        end else if (w_state_nxt == c_ST_RUN) begin
            slow_clk_en <= wd_en & hif_active;
        end else begin
            slow_clk_en <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/rcm_seq.md
RCM_SEQ -- requirements
Module: rcm_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, depth of the reset synchroniser chain; legal values are 2 and above.
REQ-002 Parameter N_CH, default 4, number of sequenced reset domains; legal values are 1 to 16.
REQ-003 Parameter DLY_W, default 4, width of the stagger delay field.
REQ-004 Parameter WD_W, default 16, width of the watchdog counter and limit.
REQ-005 Port xtal_clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-006 Port por_rst, input, 1 bit: reset; asynchronous, active-high.
REQ-007 Port sw_rst_req, input, 1 bit: synchronous software reset request, sampled each cycle.
REQ-008 Port hif_active, input, 1 bit: interface ACTIVE bit, synchronous to xtal_clk.
REQ-009 Port hif_scl, input, 1 bit: raw SCL, asynchronous, synchronised internally.
REQ-010 Port wd_en, input, 1 bit: watchdog enable.
REQ-011 Port wd_limit, input, WD_W bits: watchdog timeout in cycles; 0 disables the watchdog.
REQ-012 Port stagger, input, DLY_W bits: idle cycles between successive channel releases.
REQ-013 Port rst_n, output, N_CH bits: per-domain active-low resets; bit 0 is released first.
REQ-014 Port rst_done, output, 1 bit: all domains are released.
REQ-015 Port wd_timeout, output, 1 bit: one-cycle watchdog expiry pulse.
REQ-016 Port slow_clk_en, output, 1 bit: ring-oscillator enable.

Function
REQ-017 An internal SYNC_STAGES-flop chain SHALL shift in 1 each cycle while por_rst is low; sync_ok is the last stage.
REQ-018 When sw_rst_req is 1, the chain SHALL be cleared synchronously on that edge, forcing sync_ok to 0 so the synchroniser wait restarts.
REQ-019 The FSM SHALL have three states: ASSERT, RELEASE and RUN.
- In ASSERT, rst_n is all 0, rst_done is 0, and the FSM stays until sync_ok is 1.
- On the edge where sync_ok is 1, the FSM moves to RELEASE with idx=0 and cnt=0.
REQ-020 In RELEASE, the stagger counter and release index SHALL behave as follows:
- cnt increments each cycle.
- On the edge where cnt==stagger, rst_n[idx] is set to 1, cnt returns to 0 and idx increments.
- stagger is sampled every cycle; a change takes effect on the next compare.
REQ-021 Each rst_n bit SHALL rise stagger+1 edges after the previous release, or after RELEASE entry for bit 0; stagger=0 releases one bit per cycle.
REQ-022 On the edge that releases rst_n[N_CH-1], the FSM SHALL enter RUN and rst_done SHALL go to 1 on that same edge.
REQ-023 Once set, a bit of rst_n SHALL stay 1 until por_rst or sw_rst_req.
REQ-024 When sw_rst_req is 1 in RELEASE or RUN, on the next edge rst_n SHALL be 0, rst_done 0, the state ASSERT, and cnt and idx 0.
REQ-025 When sw_rst_req is 1 in ASSERT, it SHALL only restart the synchroniser chain.
REQ-026 hif_scl SHALL be passed through a 2-flop synchroniser plus one history flop; scl_edge is the XOR of the last two.
REQ-027 The watchdog counter SHALL count only when all of these hold: state is RUN, wd_en is 1, hif_active is 1, and wd_limit is not 0.
- If any of these is false, the counter is held at 0 and wd_timeout is 0.
REQ-028 While counting, the watchdog counter SHALL update as follows:
- scl_edge clears the counter; scl_edge takes priority over expiry in the same cycle.
- Otherwise, if counter==wd_limit, the counter goes to 0 and wd_timeout is registered 1 for exactly one cycle.
- Otherwise, the counter increments.
REQ-029 Expiry SHALL repeat every wd_limit+1 cycles of SCL inactivity, and the counter SHALL never wrap.
REQ-030 slow_clk_en SHALL be registered: 1 in ASSERT and RELEASE; in RUN it equals wd_en & hif_active from the previous cycle.
REQ-031 All outputs SHALL be driven directly from flops.

Reset
REQ-032 While por_rst is 1, all of the following SHALL hold asynchronously:
- rst_n is all 0, rst_done is 0, wd_timeout is 0, slow_clk_en is 1.
- State is ASSERT; the chain, cnt, idx, the watchdog counter and the SCL flops are all 0.
REQ-033 por_rst asserted mid-RELEASE or mid-RUN SHALL immediately re-assert every rst_n bit and restart the full sequence after deassertion.

Verification (SYNC_STAGES=2, N_CH=4; edges counted from the first rising edge after por_rst falls)
REQ-034 Deassert por_rst with stagger=2. Required: RELEASE is entered at edge 3; rst_n = 0001 @6, 0011 @9, 0111 @12, 1111 @15; rst_done rises @15.
REQ-035 stagger=0. Required: rst_n bits rise on consecutive edges 4, 5, 6, 7, with rst_done @7.
REQ-036 In RUN, pulse sw_rst_req for one cycle. Required:
- Next edge: rst_n=0000 and rst_done=0.
- The sequence then repeats from the synchroniser wait, with the same relative timing as REQ-034.
REQ-037 In RUN, set wd_en=1, hif_active=1, wd_limit=5, and hold SCL static. Required: wd_timeout pulses for one cycle every 6 cycles.
REQ-038 Same setup as REQ-037, toggling SCL every 4 cycles. Required: no wd_timeout.
REQ-039 Same setup as REQ-037 with wd_limit=0. Required: no wd_timeout.
REQ-040 Assert por_rst asynchronously between edges with rst_n=0011. Required: rst_n=0000 and slow_clk_en=1 before the next edge.
